dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a fixed access delay.
// Accepts one request at a time, waits WAIT cycles, then performs the access.
// The response is held until the core takes it.
module dmem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        access;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        acc_err;
  logic [IdxW-1:0] acc_idx;
  logic        mem_we;

  logic [31:0] mem [DEPTH];

  assign accept = req_valid & req_ready;

  // Source of the access: with no wait cycles the access happens on the
  // accept edge itself, so it uses the request directly; otherwise it uses
  // the copy captured at accept.
  if (WAIT == 0) begin : g_direct
    assign access    = accept;
    assign acc_we    = req_we;
    assign acc_addr  = req_addr;
    assign acc_wdata = req_wdata;
    assign acc_wstrb = req_wstrb;
  end else begin : g_reg
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Capture the request on accept; later req_* changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end else if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end

    assign access    = (state_q == StWait) && (cnt_q == 4'd0);
    assign acc_we    = we_q;
    assign acc_addr  = addr_q;
    assign acc_wdata = wdata_q;
    assign acc_wstrb = wstrb_q;
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
  assign acc_idx = acc_addr[IdxW+1:2];
  // reset_n gate keeps a zero-wait accept seen during reset from writing.
  assign mem_we  = access & acc_we & ~acc_err & reset_n;

  // FSM state and wait counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from the state register only.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  // Response payload is loaded at the access and otherwise held.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
    end
  end

  // Response payload register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Storage is never reset; only strobed lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT=2 instance driven transaction by
// transaction and a WAIT=0 instance streamed back to back, both checked
// against a word-array reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned WAIT_A = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic        a_req_valid = 0, a_req_ready, a_req_we = 0;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic [3:0]  a_req_wstrb = 0;
  logic        a_rsp_valid, a_rsp_ready = 0, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 0, b_req_ready, b_req_we = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic [3:0]  b_req_wstrb = 0;
  logic        b_rsp_valid, b_rsp_ready = 0, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  // Reference memories, one per instance.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];

  function automatic void ref_access(input bit sel, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] strb,
                                     output logic [31:0] rdata, output logic err);
    int unsigned w;
    logic [31:0] cur;
    w     = addr / 4;
    err   = (addr % 4 != 0) || (w >= DEPTH);
    rdata = 32'd0;
    if (!err) begin
      cur = sel ? mem_b[w] : mem_a[w];
      if (we) begin
        for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = wdata[8*i +: 8];
        if (sel) mem_b[w] = cur;
        else mem_a[w] = cur;
      end else begin
        rdata = cur;
      end
    end
  endfunction

  // One transaction on the WAIT=2 instance; reports what it observed.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int hold, input bit early,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output bit stable, output bit post_ok);
    int guard;
    @(negedge clk);
    a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    a_req_wstrb = strb; a_rsp_ready = 0;
    guard = 0;
    while (a_req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    a_req_valid = 0;
    a_req_we = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom;
    a_req_wstrb = 4'($urandom);
    if (early) a_rsp_ready = 1;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      a_rsp_ready = 0;
    end
    rdata = a_rsp_rdata;
    err = a_rsp_err;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0 || a_rsp_rdata !== rdata ||
          a_rsp_err !== err) stable = 0;
    end
    a_rsp_ready = 1;
    @(posedge clk);
    #1;
    a_rsp_ready = 0;
    post_ok = (a_rsp_valid === 1'b0) && (a_req_ready === 1'b1) && (a_rsp_rdata === rdata) &&
              (a_rsp_err === err);
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a: got rdy=%b vld=%b rdata=%h err=%b want 1 0 0 0",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    n_chk++;
    if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_b: got rdy=%b vld=%b rdata=%h err=%b want 1 0 0 0",
               b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_prefill();
    logic [31:0] r, er, d; logic e, ee; int lat, bad; bit st, po;
    bad = 0;
    for (int w = 0; w < int'(DEPTH); w++) begin
      d = $urandom;
      ref_access(0, 1, 32'(w * 4), d, 4'hF, er, ee);
      txn_a(1, 32'(w * 4), d, 4'hF, 0, 0, r, e, lat, st, po);
      if (r !== er || e !== ee || lat != int'(WAIT_A) + 1 || !po) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL prefill: got %0d bad stores want 0", bad);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] r, er; logic e, ee; int lat; bit st, po;
    ref_access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee);
    txn_a(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, e, lat, st, po);
    n_chk++;
    if (lat != int'(WAIT_A) + 1) begin
      n_err++; $display("FAIL store_latency: got %0d want %0d", lat, WAIT_A + 1);
    end
    n_chk++;
    if ({r, e} !== {32'd0, 1'b0} || !po) begin
      n_err++; $display("FAIL store_rsp: got rdata=%h err=%b post=%b want 0 0 1", r, e, po);
    end
    ref_access(0, 0, 32'h10, 32'd0, 4'h0, er, ee);
    txn_a(0, 32'h10, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if (lat != int'(WAIT_A) + 1) begin
      n_err++; $display("FAIL load_latency: got %0d want %0d", lat, WAIT_A + 1);
    end
    n_chk++;
    if (r !== 32'hDEADBEEF || r !== er || e !== 1'b0) begin
      n_err++; $display("FAIL load_deadbeef: got %h err=%b want deadbeef err=0", r, e);
    end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] r, er; logic e, ee; int lat; bit st, po;
    ref_access(0, 1, 32'h10, 32'h00AA0000, 4'h4, er, ee);
    txn_a(1, 32'h10, 32'h00AA0000, 4'h4, 0, 0, r, e, lat, st, po);
    ref_access(0, 0, 32'h10, 32'd0, 4'h0, er, ee);
    txn_a(0, 32'h10, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if (r !== 32'hDEAABEEF || r !== er || e !== 1'b0) begin
      n_err++; $display("FAIL byte_strobe: got %h err=%b want deaabeef err=0", r, e);
    end
    // wstrb=0 store must change nothing
    txn_a(1, 32'h10, 32'h12345678, 4'h0, 0, 0, r, e, lat, st, po);
    txn_a(0, 32'h10, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if (r !== 32'hDEAABEEF || e !== 1'b0) begin
      n_err++; $display("FAIL zero_strobe: got %h err=%b want deaabeef err=0", r, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r, er; logic e, ee; int lat, bad; bit st, po;
    txn_a(0, 32'h13, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if ({r, e} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL misaligned_load: got rdata=%h err=%b want 0 1", r, e);
    end
    txn_a(0, 32'h400, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if ({r, e} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL range_load: got rdata=%h err=%b want 0 1", r, e);
    end
    txn_a(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, r, e, lat, st, po);
    n_chk++;
    if ({r, e} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL range_store: got rdata=%h err=%b want 0 1", r, e);
    end
    txn_a(1, 32'h11, 32'hFFFFFFFF, 4'hF, 0, 0, r, e, lat, st, po);
    bad = 0;
    for (int w = 0; w < int'(DEPTH); w++) begin
      ref_access(0, 0, 32'(w * 4), 32'd0, 4'h0, er, ee);
      txn_a(0, 32'(w * 4), 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
      if (r !== er || e !== ee) begin
        if (bad == 0) $display("FAIL storage_word %0d: got %h want %h", w, r, er);
        bad++;
      end
    end
    n_chk++;
    if (bad != 0) begin
      n_err++; $display("FAIL storage_unchanged: got %0d bad words want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, er; logic e, ee; int lat; bit st, po;
    ref_access(0, 0, 32'h44, 32'd0, 4'h0, er, ee);
    txn_a(0, 32'h44, 32'd0, 4'h0, 5, 0, r, e, lat, st, po);
    n_chk++;
    if (!st) begin
      n_err++; $display("FAIL hold_stable: got unstable want stable over 5 cycles");
    end
    n_chk++;
    if (!po) begin
      n_err++; $display("FAIL hold_release: got vld=%b rdy=%b want 0 1", a_rsp_valid, a_req_ready);
    end
    n_chk++;
    if (r !== er || e !== ee) begin
      n_err++; $display("FAIL hold_data: got %h/%b want %h/%b", r, e, er, ee);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, old; logic e; int lat; bit st, po;
    old = mem_a[8];
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = ~old; a_req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    a_req_valid = 0;
    n_chk++;
    if (a_req_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_accepted: got rdy=%b want 0", a_req_ready);
    end
    #2 reset_n = 0;
    #1;
    n_chk++;
    if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got rdy=%b vld=%b rdata=%h err=%b want 1 0 0 0",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    txn_a(0, 32'h20, 32'd0, 4'h0, 0, 0, r, e, lat, st, po);
    n_chk++;
    if (r !== old || e !== 1'b0) begin
      n_err++; $display("FAIL mid_discard: got %h err=%b want %h err=0", r, e, old);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er, addr, d; logic e, ee, we; logic [3:0] s;
    int lat, hold, kind, bad; bit st, po, early;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 6) addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 8) addr = 32'($urandom_range(DEPTH, 1023)) * 4;
      else addr = $urandom | 32'h8000_0000;
      we = 1'($urandom); d = $urandom; s = 4'($urandom);
      hold = int'($urandom_range(0, 3)); early = ($urandom_range(0, 3) == 0);
      ref_access(0, we, addr, d, s, er, ee);
      txn_a(we, addr, d, s, hold, early, r, e, lat, st, po);
      n_chk++;
      if (r !== er || e !== ee || lat != int'(WAIT_A) + 1 || !st || !po) begin
        n_err++;
        $display("FAIL rand_%0d addr=%h we=%b: got %h/%b lat=%0d st=%b po=%b want %h/%b lat=%0d",
                 n, addr, we, r, e, lat, st, po, er, ee, WAIT_A + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    logic        op_we   [N];
    logic [31:0] op_addr [N];
    logic [31:0] op_data [N];
    logic [3:0]  op_strb [N];
    logic [31:0] er; logic ee, rdy;
    int idx, cyc, last, kind;
    for (int i = 0; i < N; i++) begin
      op_data[i] = $urandom;
      if (i < 16) begin
        op_we[i] = 1; op_addr[i] = 32'(i * 4); op_strb[i] = 4'hF;
      end else begin
        kind = int'($urandom_range(0, 5));
        op_we[i] = (kind == 3);
        op_strb[i] = 4'($urandom);
        if (kind == 4) op_addr[i] = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        else if (kind == 5) op_addr[i] = 32'h400 + 32'($urandom_range(0, 63)) * 4;
        else op_addr[i] = 32'($urandom_range(0, 15)) * 4;
      end
    end
    b_rsp_ready = 1;
    @(negedge clk);
    b_req_valid = 1; b_req_we = op_we[0]; b_req_addr = op_addr[0];
    b_req_wdata = op_data[0]; b_req_wstrb = op_strb[0];
    rdy = b_req_ready;
    idx = 0; cyc = 0; last = 0;
    while (idx < N && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rdy === 1'b1) begin
        ref_access(1, op_we[idx], op_addr[idx], op_data[idx], op_strb[idx], er, ee);
        n_chk++;
        if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_valid_%0d: got vld=%b rdy=%b want 1 0", idx, b_rsp_valid, b_req_ready);
        end
        n_chk++;
        if (b_rsp_rdata !== er || b_rsp_err !== ee) begin
          n_err++;
          $display("FAIL b2b_data_%0d addr=%h: got %h/%b want %h/%b",
                   idx, op_addr[idx], b_rsp_rdata, b_rsp_err, er, ee);
        end
        if (idx > 0) begin
          n_chk++;
          if (cyc - last != 2) begin
            n_err++; $display("FAIL b2b_spacing_%0d: got %0d want 2", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < N) begin
          b_req_we = op_we[idx]; b_req_addr = op_addr[idx];
          b_req_wdata = op_data[idx]; b_req_wstrb = op_strb[idx];
        end else begin
          b_req_valid = 0;
        end
      end
      rdy = b_req_ready;
    end
    n_chk++;
    if (idx != N) begin
      n_err++; $display("FAIL b2b_timeout: got %0d accepts want %0d", idx, N);
    end
    b_rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_store_load();
    test_byte_strobe();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

endmodule
